// File: rtl/pcie_lector.sv
// Reads words from the two PCIe output FIFOs D0/D1 round-robin and delivers them
// two cycles after each pop, with per-source counts and a destination-bit check.
module pcie_lector #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              init,
  input  logic              empty_D0,
  input  logic              empty_D1,
  input  logic [DATA_W-1:0] data_out0,
  input  logic [DATA_W-1:0] data_out1,
  input  logic              idle_out,
  input  logic              error_out,
  input  logic              hold,
  output logic              pop_D0,
  output logic              pop_D1,
  output logic [DATA_W-1:0] data_rx,
  output logic              valid_rx,
  output logic              src_rx,
  output logic [CNT_W-1:0]  cnt_D0,
  output logic [CNT_W-1:0]  cnt_D1,
  output logic              err_rx,
  output logic              done,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    ACTIVE = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state, state_nx;
  logic              pend_v;
  logic              pend_src;
  logic              last_src;
  logic [DATA_W-1:0] word;

  assign state_dbg = state;
  assign word      = pend_src ? data_out1 : data_out0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= INIT;
    end else begin
      state <= state_nx;
    end
  end

  // Pop strobes act as the read handshake: a FIFO is popped only in a cycle where
  // its empty flag is low, and its word appears on data_outX in the following cycle.
  always_comb begin
    state_nx = state;
    pop_D0   = 1'b0;
    pop_D1   = 1'b0;
    if (init) begin
      state_nx = INIT;
    end else begin
      case (state)
        INIT:    state_nx = ACTIVE;
        ACTIVE:  if (error_out || err_rx) state_nx = HALT;
        default: state_nx = HALT;
      endcase
    end
    // A flagged routing error stops new pops in the very cycle it is reported.
    if (state == ACTIVE && !hold && !init && !err_rx) begin
      if (!empty_D0 && (empty_D1 || last_src)) begin
        pop_D0 = 1'b1;
      end else if (!empty_D1) begin
        pop_D1 = 1'b1;
      end
    end
  end

  assign done = (state == ACTIVE) && idle_out && empty_D0 && empty_D1 && !pend_v;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pend_v   <= 1'b0;
      pend_src <= 1'b0;
      last_src <= 1'b1;
      valid_rx <= 1'b0;
      data_rx  <= '0;
      src_rx   <= 1'b0;
      cnt_D0   <= '0;
      cnt_D1   <= '0;
      err_rx   <= 1'b0;
    end else if (init) begin
      pend_v   <= 1'b0;
      pend_src <= 1'b0;
      last_src <= 1'b1;
      valid_rx <= 1'b0;
      data_rx  <= '0;
      src_rx   <= 1'b0;
      cnt_D0   <= '0;
      cnt_D1   <= '0;
      err_rx   <= 1'b0;
    end else begin
      pend_v   <= pop_D0 | pop_D1;
      valid_rx <= pend_v;
      if (pop_D0 | pop_D1) begin
        pend_src <= pop_D1;
        last_src <= pop_D1;
      end
      // Outstanding pops complete regardless of state, so HALT and hold still deliver.
      if (pend_v) begin
        data_rx <= word;
        src_rx  <= pend_src;
        if (word[DATA_W-2] != pend_src) err_rx <= 1'b1;
        if (pend_src) begin
          if (cnt_D1 != CNT_MAX) cnt_D1 <= cnt_D1 + CNT_ONE;
        end else begin
          if (cnt_D0 != CNT_MAX) cnt_D0 <= cnt_D0 + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: doc/pcie_lector.md
PCIE_LECTOR -- requirements
Module: pcie_lector

Interface
REQ-001 SHALL have parameter DATA_W, default 6, word width of the D0/D1 output FIFOs.
REQ-002 SHALL have parameter CNT_W, default 8, width of the per-FIFO word counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port init  input  1  synchronous re-initialisation request, active high.
REQ-006 SHALL have port empty_D0 / empty_D1  input  1 each  empty flag of output FIFO D0 / D1.
REQ-007 SHALL have port data_out0 / data_out1  input  DATA_W each  read data of D0 / D1, valid the cycle after a pop.
REQ-008 SHALL have port idle_out / error_out  input  1 each  idle and error status of the PCIE transaction block.
REQ-009 SHALL have port hold  input  1  downstream backpressure; blocks new pops.
REQ-010 SHALL have port pop_D0 / pop_D1  output  1 each  read strobe to D0 / D1.
REQ-011 SHALL have port data_rx  output  DATA_W  captured word.
REQ-012 SHALL have port valid_rx  output  1  data_rx valid this cycle (one-cycle pulse per word).
REQ-013 SHALL have port src_rx  output  1  source of data_rx: 0 = D0, 1 = D1.
REQ-014 SHALL have ports cnt_D0 / cnt_D1  output  CNT_W each  words received from D0 / D1.
REQ-015 SHALL have port err_rx  output  1  sticky routing-error flag.
REQ-016 SHALL have port done  output  1  all traffic drained.

Function
REQ-017 SHALL implement three states: INIT, ACTIVE, HALT.
REQ-018 SHALL leave INIT for ACTIVE on the first clock with init=0; SHALL enter INIT from any state on a clock with init=1.
REQ-019 SHALL enter HALT from ACTIVE when error_out=1 or err_rx=1; HALT SHALL exit only via init or reset.
REQ-020 SHALL drive pop_D0/pop_D1 combinationally, only in ACTIVE with hold=0 and no init, and never both in one cycle.
REQ-021 SHALL pop Dx only while empty_Dx=0 in the same cycle; a pop on an empty FIFO is forbidden.
REQ-022 SHALL arbitrate round-robin when both FIFOs are non-empty: serve the FIFO not served by the last pop; after reset or init, D0 has priority.
REQ-023 SHALL, when only one FIFO is non-empty, pop it every eligible cycle (back-to-back pops allowed).
REQ-024 SHALL sample data_outX in cycle N+1 for a pop in cycle N and present data_rx, src_rx, valid_rx=1 in cycle N+2 (latency 2), at a throughput of one word per cycle.
REQ-025 SHALL complete a pop outstanding on entry to HALT or on assertion of hold (its word is delivered).
REQ-026 SHALL discard a pop outstanding on assertion of init (no valid_rx, no count).
REQ-027 SHALL increment cnt_D0/cnt_D1 on each delivered word from that source and saturate at 2^CNT_W-1 (255 by default), with no wrap.
REQ-028 SHALL check bit DATA_W-2 (destination bit) of each delivered word: it must equal src_rx; on mismatch, set err_rx in the delivery cycle and hold it until init or reset.
REQ-029 SHALL assert done combinationally when state=ACTIVE, idle_out=1, empty_D0=empty_D1=1 and no pop is outstanding.
REQ-030 SHALL keep data_rx and src_rx at their last delivered values when valid_rx=0.

Reset
REQ-031 SHALL, on reset_L=0 and independent of clk, force: state INIT; pop_D0/pop_D1 0; data_rx 0; valid_rx 0; src_rx 0; cnt_D0/cnt_D1 0; err_rx 0; outstanding-pop pipeline cleared; round-robin priority to D0.
REQ-032 SHALL apply the same values as REQ-031 on init=1 at a clock edge.
REQ-033 SHALL begin operation on the first rising edge after reset_L deasserts, in state INIT.

Verification
REQ-034 SHALL cover: reset then init=0, both FIFOs empty, idle_out=1 -> no pops, done=1, all outputs 0.
REQ-035 SHALL cover: D0 holds 0x05, 0x0A and D1 holds 0x15 -> pops D0, D1, D0 in consecutive cycles; valid_rx outputs 0x05/src 0, 0x15/src 1, 0x0A/src 0 from 2 cycles later; cnt_D0=2, cnt_D1=1; err_rx=0.
REQ-036 SHALL cover: D1 delivers 0x03 (bit4=0) -> err_rx=1 on delivery; the next cycle goes to HALT, no further pops; init pulse -> err_rx=0 and counters 0.
REQ-037 SHALL cover: hold=1 raised the cycle after a D0 pop -> that word is still delivered, then no pops until hold=0.
REQ-038 SHALL cover: error_out=1 during traffic -> HALT, pops stop, the outstanding word is delivered, done=0.
REQ-039 SHALL cover: 300 words from D0 -> cnt_D0 saturates at 255; reset_L pulsed mid-pop -> all outputs 0 immediately, with no valid_rx afterwards.
